// File: rtl/mdu_pkg.sv
// Shared types and operation decode helpers for the RV32M multiply/divide unit.
package mduPkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_div(input mdu_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_rem(input mdu_op_t op);
        return op inside {REM, REMU};
    endfunction

    // MUL only keeps the low half, which is identical for any signedness.
    function automatic logic is_signed_a(input mdu_op_t op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(input mdu_op_t op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/mdu.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sharing one XLEN+1-bit adder, sign fix-up at the end.
module mdu
    import mduPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] mdu_in1,
    input  logic [XLEN-1:0] mdu_in2,
    input  logic [2:0]      mdu_op,
    input  logic            mdu_start,
    output logic            mdu_busy,
    output logic            mdu_valid,
    output logic [XLEN-1:0] mdu_out
);

    localparam logic [5:0]        LAST_ITER = 6'(XLEN - 1);
    localparam logic [XLEN-1:0]   ONE_X     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X    = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + ONE_X;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + ONE_2X;
    endfunction

    mdu_state_t        r_state;
    mdu_state_t        w_next;
    logic [5:0]        r_cnt;
    mdu_op_t           r_op;
    logic              r_qneg;
    logic              r_rneg;
    logic              r_spec;
    logic [XLEN-1:0]   r_spec_val;
    logic [XLEN-1:0]   r_mag;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_out;

    mdu_op_t           w_op_in;
    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_spec;
    logic [XLEN-1:0]   w_spec_val;

    assign w_op_in  = mdu_op_t'(mdu_op);
    assign w_accept = mdu_start && ((r_state == IDLE) || (r_state == DONE));

    assign w_a_neg = is_signed_a(w_op_in) && mdu_in1[XLEN-1];
    assign w_b_neg = is_signed_b(w_op_in) && mdu_in2[XLEN-1];
    assign w_a_mag = w_a_neg ? neg_x(mdu_in1) : mdu_in1;
    assign w_b_mag = w_b_neg ? neg_x(mdu_in2) : mdu_in2;

    // Division corner cases are resolved at acceptance and bypass the iteration loop.
    assign w_div_zero = is_div(w_op_in) && (mdu_in2 == '0);
    assign w_ovf      = ((w_op_in == DIV) || (w_op_in == REM)) &&
                        (mdu_in1 == MIN_NEG) && (mdu_in2 == '1);
    assign w_spec     = w_div_zero || w_ovf;

    always_comb begin
        w_spec_val = '0;
        if (w_div_zero) begin
            w_spec_val = is_rem(w_op_in) ? mdu_in1 : '1;
        end else if (w_ovf) begin
            w_spec_val = is_rem(w_op_in) ? '0 : MIN_NEG;
        end
    end

    // Shared adder: multiply adds the multiplicand into the high half,
    // divide subtracts the divisor from the shifted partial remainder.
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic              w_div;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN+1:0]   w_sum;
    logic              w_no_borrow;
    logic [2*XLEN-1:0] w_acc_mul;
    logic [2*XLEN-1:0] w_acc_div;
    logic [2*XLEN-1:0] w_acc_next;

    assign w_hi  = r_acc[2*XLEN-1:XLEN];
    assign w_lo  = r_acc[XLEN-1:0];
    assign w_div = is_div(r_op);

    assign w_add_a = w_div ? {w_hi, w_lo[XLEN-1]} : {1'b0, w_hi};
    assign w_add_b = w_div ? ~{1'b0, r_mag} : (w_lo[0] ? {1'b0, r_mag} : '0);
    assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_div};

    assign w_no_borrow = w_sum[XLEN+1];
    assign w_acc_mul   = {w_sum[XLEN:0], w_lo[XLEN-1:1]};
    assign w_acc_div   = {(w_no_borrow ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0]),
                          w_lo[XLEN-2:0], w_no_borrow};
    assign w_acc_next  = w_div ? w_acc_div : w_acc_mul;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    assign w_prod = r_qneg ? neg_2x(r_acc) : r_acc;
    assign w_quo  = r_qneg ? neg_x(w_lo) : w_lo;
    assign w_rem  = r_rneg ? neg_x(w_hi) : w_hi;

    always_comb begin
        w_result = '0;
        if (r_spec) begin
            w_result = r_spec_val;
        end else begin
            unique case (r_op)
                MUL:                 w_result = w_prod[XLEN-1:0];
                MULH, MULHSU, MULHU: w_result = w_prod[2*XLEN-1:XLEN];
                DIV, DIVU:           w_result = w_quo;
                REM, REMU:           w_result = w_rem;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        mdu_busy  = 1'b0;
        mdu_valid = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                mdu_valid = (r_state == DONE);
                if (w_accept) begin
                    w_next = w_spec ? FIX : CALC;
                end else begin
                    w_next = IDLE;
                end
            end
            CALC: begin
                mdu_busy = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                mdu_busy = 1'b1;
                w_next   = DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= MUL;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_mag      <= '0;
            r_acc      <= '0;
            r_out      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= w_op_in;
                r_spec     <= w_spec;
                r_spec_val <= w_spec_val;
                r_qneg     <= w_a_neg ^ w_b_neg;
                r_rneg     <= w_a_neg;
                r_mag      <= is_div(w_op_in) ? w_b_mag : w_a_mag;
                r_acc      <= {{XLEN{1'b0}}, (is_div(w_op_in) ? w_a_mag : w_b_mag)};
                r_cnt      <= '0;
            end else if (r_state == CALC) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 6'd1;
            end
            if (r_state == FIX) begin
                r_out <= w_result;
            end
        end
    end

    assign mdu_out = r_out;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed RV32M vectors with literal expectations, plus a
// timeline/arithmetic reference model compared against the outputs every cycle.
module tb_mdu;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mdu_in1 = '0;
    logic [31:0] mdu_in2 = '0;
    logic [2:0]  mdu_op = '0;
    logic        mdu_start = 1'b0;
    logic        mdu_busy;
    logic        mdu_valid;
    logic [31:0] mdu_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdu_in1   (mdu_in1),
        .mdu_in2   (mdu_in2),
        .mdu_op    (mdu_op),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy),
        .mdu_valid (mdu_valid),
        .mdu_out   (mdu_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        qa = a;
        qb = b;
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(qa / qb);
            end
            OP_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(qa % qb);
            end
            OP_DIVU: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'h0 ||
            ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    // Timeline model: cycle index of the current cycle, cycle in which the
    // pending result is due, and the output value held between results.
    logic        m_pend = 1'b0;
    int          m_cur = 0;
    int          m_vcyc = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_cur  <= 0;
            m_vcyc <= 0;
            m_res  <= '0;
            m_out  <= '0;
        end else begin
            m_cur <= m_cur + 1;
            if (m_pend && (m_cur + 1 == m_vcyc)) m_out <= m_res;
            if (mdu_start && !(m_pend && m_cur < m_vcyc)) begin
                m_pend <= 1'b1;
                m_vcyc <= m_cur + ref_latency(mdu_op, mdu_in1, mdu_in2);
                m_res  <= ref_result(mdu_op, mdu_in1, mdu_in2);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",  32'(mdu_busy),  32'(m_pend && (m_cur < m_vcyc)));
        chk("cyc_valid", 32'(mdu_valid), 32'(m_pend && (m_cur == m_vcyc)));
        chk("cyc_out",   mdu_out,        m_out);
    end

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_op    = op;
        mdu_in1   = a;
        mdu_in2   = b;
        mdu_start = 1'b1;
        @(posedge clk);
        #1;
        mdu_start = 1'b0;
        mdu_in1   = $urandom;
        mdu_in2   = $urandom;
        mdu_op    = 3'($urandom_range(7));
    endtask

    // Counts negedges from now until valid (bounded); returns in the valid cycle.
    task automatic wait_result(input string name, input logic [31:0] exp, input int lat);
        int n = 0;
        int nbusy = 0;
        bit got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (mdu_valid) got = 1'b1;
            else if (mdu_busy) nbusy++;
        end
        chk({name, "_lat"},  32'(n), 32'(lat));
        chk({name, "_out"},  mdu_out, exp);
        chk({name, "_busy"}, 32'(nbusy), 32'(lat - 1));
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        start_op(op, a, b);
        wait_result(name, exp, lat);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(mdu_busy),  32'h0);
        chk("rst_valid", 32'(mdu_valid), 32'h0);
        chk("rst_out",   mdu_out,        32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul",      OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("mulh",     OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        do_op("mulhsu",   OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        do_op("mulhu",    OP_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34);
        do_op("mulhu_ff", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("div",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        do_op("rem",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        do_op("rem_nb",   OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34);
        do_op("div_max",  OP_DIV,    32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 34);
        do_op("divu",     OP_DIVU,   32'd100,       32'd7,         32'd14,        34);
        do_op("remu",     OP_REMU,   32'd100,       32'd7,         32'd2,         34);
        do_op("remu_big", OP_REMU,   32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);
        do_op("div_z",    OP_DIV,    32'h1234,      32'h0,         32'hFFFF_FFFF, 2);
        do_op("rem_z",    OP_REM,    32'h1234,      32'h0,         32'h1234,      2);
        do_op("divu_z",   OP_DIVU,   32'd5,         32'h0,         32'hFFFF_FFFF, 2);
        do_op("remu_z",   OP_REMU,   32'd5,         32'h0,         32'd5,         2);
        do_op("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        do_op("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2);

        // start held high with scrambled operands while busy must be ignored
        mdu_op    = OP_DIVU;
        mdu_in1   = 32'd100;
        mdu_in2   = 32'd7;
        mdu_start = 1'b1;
        @(posedge clk);
        #1;
        repeat (29) begin
            mdu_in1 = $urandom;
            mdu_in2 = 32'h0;
            mdu_op  = 3'($urandom_range(7));
            @(posedge clk);
            #1;
        end
        mdu_start = 1'b0;
        wait_result("held", 32'd14, 5);
        @(negedge clk);
        chk("held_keep", mdu_out, 32'd14);

        // second request issued in the DONE cycle
        start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_result("b2b_1", 32'hFFFF_FFEB, 34);
        start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("b2b_2", 32'hFFFF_FFFE, 34);
        @(negedge clk);

        // asynchronous reset in the middle of a divide
        start_op(OP_DIV, 32'h1234_5678, 32'd3);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(mdu_busy),  32'h0);
        chk("arst_valid", 32'(mdu_valid), 32'h0);
        chk("arst_out",   mdu_out,        32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post_rst", OP_MUL, 32'd3, 32'd5, 32'd15, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
